// File: rtl/mult32_seq_ctrl.sv
// Sequential shift-add multiplier: 32 shift-add steps, a two's-complement fix-up, and a one-cycle DONE.
// Signed operands are multiplied as magnitudes, and the sign is applied to the 64-bit product at the end.
module mult32_seq_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   mcnd_r;
    logic [DATA_WIDTH-1:0]   prod_hi_r;
    logic [DATA_WIDTH-1:0]   prod_lo_r;
    logic                    neg_r;
    logic                    busy_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   hi_r;
    logic [DATA_WIDTH-1:0]   lo_r;
    logic [DATA_WIDTH:0]     sum_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0] prod_neg_s;

    // The most negative value maps to its unsigned bit pattern; there is no saturation.
    function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v[DATA_WIDTH-1]) begin
            r = ~v + DATA_WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Single 33-bit adder; the carry is shifted into the upper product half.
    always_comb begin
        sum_s      = {1'b0, prod_hi_r} + {1'b0, (prod_lo_r[0] ? mcnd_r : {DATA_WIDTH{1'b0}})};
        prod_s     = {prod_hi_r, prod_lo_r};
        prod_neg_s = ~prod_s + (2*DATA_WIDTH)'(1);
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_STEP) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = FIN;
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r     <= {CNT_W{1'b0}};
            mcnd_r    <= {DATA_WIDTH{1'b0}};
            prod_hi_r <= {DATA_WIDTH{1'b0}};
            prod_lo_r <= {DATA_WIDTH{1'b0}};
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {DATA_WIDTH{1'b0}};
            lo_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        mcnd_r    <= SIGNED ? abs_mag(A) : A;
                        prod_lo_r <= SIGNED ? abs_mag(B) : B;
                        prod_hi_r <= {DATA_WIDTH{1'b0}};
                        neg_r     <= SIGNED & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    prod_hi_r <= sum_s[DATA_WIDTH:1];
                    prod_lo_r <= {sum_s[0], prod_lo_r[DATA_WIDTH-1:1]};
                    cnt_r     <= cnt_r + CNT_W'(1);
                end
                FIX: begin
                    // A zero product negates back to zero because of the full 64-bit carry.
                    {hi_r, lo_r} <= neg_r ? prod_neg_s : prod_s;
                    done_r       <= 1'b1;
                end
                FIN: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;
endmodule
